ps2_cmd_tx: RTL and testbench

Host-to-device PS/2 transmitter. It sends one command byte from the synth (for example keyboard reset 0xFF or set-LEDs 0xED followed by its LED mask) to the keyboard over the shared PS2_CLK/PS2_DAT open-drain lines. It sits beside the existing PS/2 receiver in the top level and drives the pads only through active-high pull-low enables. It reports completion, device ACK/NACK and timeouts, and raises busy so the receiver ignores line activity during a transmission.

---
 rtl/ps2_pkg.sv | 40 ++++
 rtl/ps2_line_sync.sv | 46 ++++
 rtl/ps2_cmd_tx.sv | 196 +++++++++++++++++++
 tb/tb_ps2_cmd_tx.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ============================================================================
// Module      : ps2_pkg
// Description : Shared PS/2 definitions: the transmitter state encoding,
//               host command bytes, device response bytes and the frame
//               parity helper. The receiver imports this package as well.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package ps2_pkg;

  // Transmitter state encoding
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    REQ       = 3'd2,
    SEND      = 3'd3,
    WAIT_ACK  = 3'd4,
    WAIT_IDLE = 3'd5
  } ps2_tx_state_e;

  // Host-to-device command bytes
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ECHO     = 8'hEE;

  // Device-to-host response bytes
  localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;
  localparam logic [7:0] PS2_RSP_RESEND   = 8'hFE;

  // PS/2 frames carry odd parity: the parity bit makes the count of ones
  // across data + parity odd.
  function automatic logic ps2_odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_line_sync.sv
// ============================================================================
// Module      : ps2_line_sync
// Description : Two-flop synchroniser for one asynchronous PS/2 pad plus a
//               previous-value register used to flag falling edges.
// Ports       : clk     - system clock
//               reset   - synchronous, active-low
//               line_i  - raw pad value (asynchronous)
//               sync_o  - synchronised line value
//               fall_o  - high for one cycle when the synced line goes 1->0
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module ps2_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic line_i,
  output logic sync_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Reset to the idle (released, pulled-up) level so leaving reset does not
  // look like a falling edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= line_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign fall_o = prev_q & ~sync_q;

endmodule

`default_nettype wire

// File: rtl/ps2_cmd_tx.sv
// ============================================================================
// Module      : ps2_cmd_tx
// Description : PS/2 host-to-device transmitter. Inhibits the bus, issues a
//               request-to-send, shifts out start/data/parity/stop on device
//               clock falling edges, then checks the device ACK and waits
//               for the bus to return idle. Pads are driven only through
//               active-high pull-low enables.
// Ports       : clk, reset           - clock, synchronous active-low reset
//               cmd_valid/cmd_ready  - command handshake, cmd_data captured
//               busy                 - high whenever not IDLE
//               ps2_clk_in/dat_in    - raw pad values
//               ps2_clk_oe/dat_oe    - 1 = pull line low
//               done                 - one-cycle pulse, frame ACKed
//               error/err_timeout    - one-cycle pulse, NACK (0) / timeout (1)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module ps2_cmd_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       done,
  output logic       error,
  output logic       err_timeout
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

  ps2_tx_state_e    state_q,  state_d;
  logic [7:0]       data_q,   data_d;
  logic             par_q,    par_d;
  logic [3:0]       bitcnt_q, bitcnt_d;
  logic             drv_q,    drv_d;     // 1 = data line pulled low in SEND
  logic [INH_W-1:0] inh_q,    inh_d;
  logic [TO_W-1:0]  to_q,     to_d;

  logic clk_sync, clk_fall;
  logic dat_sync, dat_fall_unused;
  logic timed;
  logic timeout_hit;

  ps2_line_sync u_clk_sync (
    .clk    (clk),
    .reset  (reset),
    .line_i (ps2_clk_in),
    .sync_o (clk_sync),
    .fall_o (clk_fall)
  );

  ps2_line_sync u_dat_sync (
    .clk    (clk),
    .reset  (reset),
    .line_i (ps2_dat_in),
    .sync_o (dat_sync),
    .fall_o (dat_fall_unused)
  );

  // The timeout covers only the phases where the device owns the clock.
  // A fall in the same cycle takes priority over an expiring count.
  assign timed       = (state_q == SEND) || (state_q == WAIT_ACK) ||
                       (state_q == WAIT_IDLE);
  assign timeout_hit = timed && !clk_fall && (to_q == TO_LIMIT);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      data_q   <= '0;
      par_q    <= 1'b0;
      bitcnt_q <= '0;
      drv_q    <= 1'b0;
      inh_q    <= '0;
      to_q     <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      par_q    <= par_d;
      bitcnt_q <= bitcnt_d;
      drv_q    <= drv_d;
      inh_q    <= inh_d;
      to_q     <= to_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    par_d    = par_q;
    bitcnt_d = bitcnt_q;
    drv_d    = drv_q;
    inh_d    = inh_q;
    to_d     = to_q;

    if (timed) begin
      if (clk_fall) begin
        to_d = '0;
      end else if (to_q != TO_LIMIT) begin
        to_d = to_q + TO_W'(1);
      end
    end

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          data_d   = cmd_data;
          par_d    = ps2_odd_parity(cmd_data);
          bitcnt_d = '0;
          inh_d    = '0;
          to_d     = '0;
          drv_d    = 1'b0;
          state_d  = INHIBIT;
        end
      end
      INHIBIT: begin
        if (inh_q == INH_LAST) begin
          state_d = REQ;
        end else begin
          inh_d = inh_q + INH_W'(1);
        end
      end
      REQ: begin
        to_d     = '0;
        bitcnt_d = '0;
        drv_d    = 1'b1;   // start bit stays on the line into SEND
        state_d  = SEND;
      end
      SEND: begin
        if (timeout_hit) begin
          state_d = IDLE;
        end else if (clk_fall) begin
          bitcnt_d = bitcnt_q + 4'd1;
          // bitcnt_q holds the number of falls seen before this one
          if (bitcnt_q <= 4'd7) begin
            drv_d = ~data_q[bitcnt_q[2:0]];
          end else if (bitcnt_q == 4'd8) begin
            drv_d = ~par_q;
          end else begin
            drv_d   = 1'b0;  // stop bit: line released
            state_d = WAIT_ACK;
          end
        end
      end
      WAIT_ACK: begin
        if (timeout_hit) begin
          state_d = IDLE;
        end else if (clk_fall) begin
          state_d = dat_sync ? IDLE : WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (timeout_hit) begin
          state_d = IDLE;
        end else if (clk_sync && dat_sync) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic. Pulses are combinational so that the cycle after a pulse
  // is already IDLE and can accept the next command; on a timeout the data
  // line is released in the same cycle the error is reported.
  always_comb begin
    cmd_ready   = (state_q == IDLE);
    busy        = (state_q != IDLE);
    ps2_clk_oe  = (state_q == INHIBIT);
    ps2_dat_oe  = (state_q == REQ) ||
                  ((state_q == SEND) && drv_q && !timeout_hit);
    done        = (state_q == WAIT_IDLE) && !timeout_hit && clk_sync && dat_sync;
    error       = timeout_hit ||
                  ((state_q == WAIT_ACK) && clk_fall && dat_sync);
    err_timeout = timeout_hit;
  end

endmodule

`default_nettype wire

// File: tb/tb_ps2_cmd_tx.sv
// ============================================================================
// Module      : tb_ps2_cmd_tx
// Description : Self-checking bench for ps2_cmd_tx with a behavioural
//               keyboard model on the open-drain lines.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ps2_cmd_tx;
  import ps2_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ready, busy, ps2_clk_oe, ps2_dat_oe, done, error, err_timeout;
  logic       ps2_clk_in, ps2_dat_in;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;

  // Open-drain wired-AND with pull-ups
  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  ps2_cmd_tx #(
    .INHIBIT_CYCLES (10),
    .TIMEOUT_CYCLES (200)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_data    (cmd_data),
    .cmd_ready   (cmd_ready),
    .busy        (busy),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_dat_in  (ps2_dat_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_dat_oe  (ps2_dat_oe),
    .done        (done),
    .error       (error),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Monitors
  int cyc          = 0;
  int done_cnt     = 0;
  int err_cnt      = 0;
  int to_cnt       = 0;
  int inh_cyc      = 0;
  int oe_bad       = 0;
  int last_err_cyc = 0;
  int last_fall_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (error) begin
      err_cnt      <= err_cnt + 1;
      last_err_cyc <= cyc;
      if (err_timeout) to_cnt <= to_cnt + 1;
      if (ps2_clk_oe || ps2_dat_oe) oe_bad <= oe_bad + 1;
    end
    if (ps2_clk_oe) inh_cyc <= inh_cyc + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Keyboard model: waits for inhibit + release, then clocks nfalls falls.
  // bits[k-1] is the data line seen at the rising edge after fall k.
  task automatic dev_run(input int nfalls, input bit ack,
                         output logic [9:0] bits, output bit stb, output bit ok);
    int n;
    bits = '0;
    stb  = 1'b1;
    ok   = 1'b0;
    n = 0;
    while (!ps2_clk_oe && n < 200) begin @(negedge clk); n++; end
    if (!ps2_clk_oe) return;
    n = 0;
    while (ps2_clk_oe && n < 200) begin @(negedge clk); n++; end
    if (ps2_clk_oe) return;
    ok = 1'b1;
    repeat (20) @(negedge clk);
    for (int k = 1; k <= nfalls; k++) begin
      if (k == 1) stb = ~(ps2_dat_oe | dev_dat_low);
      dev_clk_low   = 1'b1;
      last_fall_cyc = cyc;
      repeat (40) @(negedge clk);
      if (k <= 10) bits[k-1] = ~(ps2_dat_oe | dev_dat_low);
      dev_clk_low = 1'b0;
      dev_dat_low = 1'b0;
      if (k < nfalls) begin
        repeat (20) @(negedge clk);
        if (k == 10 && ack) dev_dat_low = 1'b1;  // ACK set up before fall 11
        repeat (20) @(negedge clk);
      end
    end
  endtask

  task automatic send(input logic [7:0] cmd, input int nfalls, input bit ack,
                      output logic [9:0] bits, output bit stb, output bit ok);
    int n;
    bit acc;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data  = cmd;
    n = 0;
    while (!cmd_ready && n < 500) begin @(negedge clk); n++; end
    acc = cmd_ready;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    chk("accepted", int'(acc), 1);
    dev_run(nfalls, ack, bits, stb, ok);
  endtask

  task automatic wait_result(input int d0, input int e0, output bit seen);
    int n;
    n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < 500) begin @(posedge clk); n++; end
    seen = !(done_cnt == d0 && err_cnt == e0);
  endtask

  typedef struct {
    logic [7:0] cmd;
    bit         ack;
    logic [9:0] frame;   // {stop, parity, data}
    bit         exp_err;
  } vec_t;

  vec_t vecs [5];

  initial begin
    logic [9:0] bits;
    bit stb, ok, seen;
    int d0, e0, t0, i0, n;

    vecs[0] = '{PS2_CMD_RESET,    1'b1, 10'h3FF, 1'b0};
    vecs[1] = '{PS2_CMD_SET_LEDS, 1'b1, 10'h3ED, 1'b0};
    vecs[2] = '{8'h02,            1'b1, 10'h202, 1'b0};
    vecs[3] = '{8'h01,            1'b0, 10'h201, 1'b1};
    vecs[4] = '{8'h00,            1'b1, 10'h300, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_clk_oe", int'(ps2_clk_oe), 0);
    chk("rst_dat_oe", int'(ps2_dat_oe), 0);
    chk("rst_pulses", int'({done, error, err_timeout}), 0);
    reset = 1'b1;

    // Table-driven frames, each presented right after the previous result
    for (int v = 0; v < 5; v++) begin
      d0 = done_cnt; e0 = err_cnt; t0 = to_cnt; i0 = inh_cyc;
      send(vecs[v].cmd, 11, vecs[v].ack, bits, stb, ok);
      chk($sformatf("v%0d_request_seen", v), int'(ok), 1);
      chk($sformatf("v%0d_start_bit", v), int'(stb), 0);
      chk($sformatf("v%0d_frame", v), int'(bits), int'(vecs[v].frame));
      wait_result(d0, e0, seen);
      chk($sformatf("v%0d_result_seen", v), int'(seen), 1);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulses", v), done_cnt - d0, vecs[v].exp_err ? 0 : 1);
      chk($sformatf("v%0d_err_pulses", v), err_cnt - e0, vecs[v].exp_err ? 1 : 0);
      chk($sformatf("v%0d_timeouts", v), to_cnt - t0, 0);
      chk($sformatf("v%0d_inhibit_cycles", v), inh_cyc - i0, 10);
      chk($sformatf("v%0d_idle", v), int'({busy, cmd_ready, ps2_clk_oe, ps2_dat_oe}), 4'b0100);
    end

    // Timeout: device stops after 4 falls
    d0 = done_cnt; e0 = err_cnt; t0 = to_cnt;
    send(8'hA5, 4, 1'b1, bits, stb, ok);
    chk("to_request_seen", int'(ok), 1);
    wait_result(d0, e0, seen);
    chk("to_result_seen", int'(seen), 1);
    @(negedge clk);
    chk("to_err_pulses", err_cnt - e0, 1);
    chk("to_flag", to_cnt - t0, 1);
    chk("to_no_done", done_cnt - d0, 0);
    chk("to_delay_ok", int'((last_err_cyc - last_fall_cyc) >= 202 &&
                            (last_err_cyc - last_fall_cyc) <= 204), 1);
    chk("err_lines_released", oe_bad, 0);
    chk("to_idle", int'({busy, cmd_ready}), 2'b01);

    // Reset in the middle of SEND after fall 5
    send(PS2_CMD_RESET, 5, 1'b1, bits, stb, ok);
    chk("mid_busy", int'(busy), 1);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_oe", int'({ps2_clk_oe, ps2_dat_oe}), 0);
    chk("mid_rst_state", int'({busy, cmd_ready}), 2'b01);
    reset = 1'b1;
    d0 = done_cnt; e0 = err_cnt;
    send(PS2_CMD_ECHO, 11, 1'b1, bits, stb, ok);
    chk("echo_frame", int'(bits), 10'h3EE);
    wait_result(d0, e0, seen);
    chk("echo_done", done_cnt - d0, 1);
    chk("echo_no_err", err_cnt - e0, 0);

    // cmd_valid held during an active frame
    d0 = done_cnt; e0 = err_cnt;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data  = PS2_CMD_ECHO;
    n = 0;
    while (!cmd_ready && n < 500) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 cmd_data = 8'h55;
    dev_run(11, 1'b1, bits, stb, ok);
    chk("hold_frame_unchanged", int'(bits), 10'h3EE);
    n = 0;
    while (!done && n < 100) begin @(negedge clk); n++; end
    chk("hold_done_seen", int'(done), 1);
    chk("hold_not_ready_in_done", int'(cmd_ready), 0);
    @(negedge clk);
    chk("hold_ready_after_done", int'({busy, cmd_ready}), 2'b01);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("hold_accepted", int'({busy, ps2_clk_oe}), 2'b11);
    dev_run(11, 1'b1, bits, stb, ok);
    chk("hold_second_frame", int'(bits), 10'h355);
    wait_result(d0 + 1, e0, seen);
    chk("hold_done_total", done_cnt - d0, 2);
    chk("hold_no_err", err_cnt - e0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
